ri5cy_ahb_master: RTL
=====================

# ri5cy_ahb_master

AHB-Lite initiator that turns a RI5CY-style req/gnt/rvalid memory port (instruction or data) into single AHB-Lite transfers, the counterpart of the AHB slaves on the SoC bus (boot ROM, RAMs, peripherals). Address and data phases are pipelined, so one transfer can be in its data phase while the next is in its address phase. The block also maps byte enables to HSIZE and address offset, and handles two-cycle ERROR responses.

## Interface
Parameters:
- AHB_ADDR_WIDTH, 32, address width (core and bus).
- AHB_DATA_WIDTH, 32, data width; only 32 supported.
- HPROT_VAL, 4'b0011, constant value driven on hprot_o.

Ports (reset rstn, synchronous, active-low; clock clk):
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- req_i  in  1  core request; held with stable addr/we/be/wdata until gnt_o.
- addr_i  in  AHB_ADDR_WIDTH  byte address, word aligned in bits [1:0] ignored.
- we_i  in  1  1 = write.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data, lane-aligned.
- gnt_o  out  1  request accepted (address phase done this cycle).
- rvalid_o  out  1  transfer finished; rdata_o/err_o valid.
- rdata_o  out  32  read data, full word.
- err_o  out  1  transfer ended with ERROR.
- haddr_o  out  AHB_ADDR_WIDTH  AHB address.
- hwrite_o  out  1  AHB write.
- hsize_o  out  3  AHB size.
- hburst_o  out  3  constant 3'b000 (SINGLE).
- hprot_o  out  4  constant HPROT_VAL.
- htrans_o  out  2  IDLE 2'b00 / NONSEQ 2'b10 only.
- hmastlock_o  out  1  constant 0.
- hwdata_o  out  32  registered write data.
- hrdata_i  in  32  AHB read data.
- hready_i  in  1  AHB ready.
- hresp_i  in  1  AHB response, 1 = ERROR.

## Operation
- FSM states: IDLE (no data phase outstanding), DATA (data phase outstanding), ERR (second cycle of an ERROR response).
- Address phase: htrans_o = NONSEQ iff req_i=1 and rstn=1 and state≠ERR and not (state=DATA and hresp_i=1). Otherwise htrans_o = IDLE.
- gnt_o = (htrans_o==NONSEQ) & hready_i. On gnt_o, capture wdata_i into hwdata_o and we_i into the data-phase flag.
- haddr_o = {addr_i[AW-1:2], off}. hwrite_o = we_i.
- be mapping:
  - 1111 -> WORD, off 0.
  - 0011 -> HALF, off 0.
  - 1100 -> HALF, off 2.
  - one-hot bit n -> BYTE, off n.
  - any other pattern -> WORD, off 0.
- Transitions:
  - IDLE: gnt_o -> DATA, else stay in IDLE.
  - DATA, hready_i=0 & hresp_i=0: stay in DATA.
  - DATA, hready_i=0 & hresp_i=1: go to ERR.
  - DATA, hready_i=1: gnt_o -> DATA, else -> IDLE.
  - ERR, hready_i=1 -> IDLE; hready_i=0: stay in ERR.
- Completion: rvalid_o=1 for exactly one cycle when DATA sees hready_i=1, or ERR sees hready_i=1.
  - rdata_o = hrdata_i (don't-care on writes).
  - err_o = 1 for completion from ERR, or from DATA with hresp_i=1; else 0.
- In the ERR first cycle a pending NONSEQ is withdrawn to IDLE. That request is not granted and is re-issued once back in IDLE.
- Reset values: state IDLE, hwdata_o 0, rvalid_o 0, err_o 0, gnt_o 0, htrans_o IDLE. Reset mid-transfer abandons the data phase; no rvalid_o is produced.

## Timing
- Fastest read: cycle N req_i & hready_i -> gnt_o in cycle N; cycle N+1 rvalid_o with hrdata_i. With registered response (see Configuration) rvalid_o comes in N+2.
- Back-to-back: a new gnt_o can coincide with the rvalid_o of the previous transfer. Throughput is 1 transfer/cycle with zero wait states.
- Wait states: each cycle of hready_i=0 in DATA delays both rvalid_o and any pending gnt_o by one cycle. The address phase outputs stay stable because req_i is held.
- hwdata_o is valid from the cycle after gnt_o until the data phase completes.
- ERROR: cycle M hresp_i=1/hready_i=0, so htrans_o=IDLE and gnt_o=0. Cycle M+1 hresp_i=1/hready_i=1, so rvalid_o=1, err_o=1, htrans_o=IDLE. The earliest next gnt_o is M+2.

## Configuration
- RI5CY_AHB_RSP_REG_EN defined: rvalid_o, rdata_o and err_o are registered (reset 0), so they appear one cycle after AHB completion. Address-phase behaviour and throughput are unchanged.
- RI5CY_AHB_RSP_REG_EN undefined: the response is combinational from hrdata_i/hresp_i/hready_i in the completion cycle, as described above.

## Test plan
- Single read, addr 0x1000, be 1111, hrdata 0xDEADBEEF, zero wait: gnt cycle 0, haddr 0x1000 hsize 010 NONSEQ, rvalid cycle 1 with rdata 0xDEADBEEF, err 0.
- Byte write be 0100, addr 0x2000, wdata 0x00AB0000: haddr 0x2002, hsize 000, hwrite 1, hwdata 0x00AB0000 in cycle 1, rvalid cycle 1.
- Three back-to-back reads, slave inserts 2 wait states on the second: gnt at cycles 0,1,4 and rvalid at 1,4,5; haddr stable through the waits.
- ERROR on a read with a second request pending: htrans IDLE in both error cycles, rvalid+err_o=1 in the second, pending request re-issued NONSEQ and granted the next cycle.
- rstn low for 1 cycle during a DATA wait state: htrans IDLE, no rvalid, state IDLE; a fresh read afterwards completes normally.
- With RI5CY_AHB_RSP_REG_EN defined, repeat test 1: rvalid in cycle 2, rdata 0xDEADBEEF.

Source files
------------

// File: rtl/ri5cy_ahb_master.sv
// RI5CY req/gnt/rvalid to AHB-Lite single-transfer initiator with pipelined address/data phases.
// Optional registered response path: define RI5CY_AHB_RSP_REG_EN.
module ri5cy_ahb_master #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_i,
  input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [AHB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [AHB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
  output logic                      hwrite_o,
  output logic [2:0]                hsize_o,
  output logic [2:0]                hburst_o,
  output logic [3:0]                hprot_o,
  output logic [1:0]                htrans_o,
  output logic                      hmastlock_o,
  output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
  input  logic                      hready_i,
  input  logic                      hresp_i
);

  typedef enum logic [1:0] {IDLE, DATA, ERR} state_e;

  state_e                    state_q;
  logic [AHB_DATA_WIDTH-1:0] hwdata_q;
  logic                      we_q;
  logic [2:0]                size;
  logic [1:0]                off;
  logic                      nonseq;
  logic                      done;
  logic                      rspErr;
  logic [AHB_DATA_WIDTH-1:0] rdata_d;
  logic                      unused_addr;

  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    size = 3'b010;
    off  = 2'd0;
    case (be_i)
      4'b1111: begin size = 3'b010; off = 2'd0; end
      4'b0011: begin size = 3'b001; off = 2'd0; end
      4'b1100: begin size = 3'b001; off = 2'd2; end
      4'b0001: begin size = 3'b000; off = 2'd0; end
      4'b0010: begin size = 3'b000; off = 2'd1; end
      4'b0100: begin size = 3'b000; off = 2'd2; end
      4'b1000: begin size = 3'b000; off = 2'd3; end
      default: begin size = 3'b010; off = 2'd0; end
    endcase
  end

  // The first ERROR cycle withdraws any pending address phase.
  assign nonseq   = req_i & rstn & (state_q != ERR) & ~((state_q == DATA) & hresp_i);
  assign gnt_o    = nonseq & hready_i;
  assign htrans_o = nonseq ? 2'b10 : 2'b00;
  assign haddr_o  = {addr_i[AHB_ADDR_WIDTH-1:2], off};
  assign hwrite_o = we_i;
  assign hsize_o  = size;
  assign hburst_o    = 3'b000;
  assign hprot_o     = HPROT_VAL;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = hwdata_q;

  assign done    = rstn & hready_i & (state_q != IDLE);
  assign rspErr  = (state_q == ERR) | ((state_q == DATA) & hresp_i);
  assign rdata_d = we_q ? '0 : hrdata_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      hwdata_q <= '0;
      we_q     <= 1'b0;
    end else begin
      if (gnt_o) begin
        hwdata_q <= wdata_i;
        we_q     <= we_i;
      end
      case (state_q)
        IDLE: state_q <= gnt_o ? DATA : IDLE;
        DATA: begin
          if (hready_i)     state_q <= gnt_o ? DATA : IDLE;
          else if (hresp_i) state_q <= ERR;
          else              state_q <= DATA;
        end
        ERR:     state_q <= hready_i ? IDLE : ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RI5CY_AHB_RSP_REG_EN
  logic                      rvalid_q;
  logic [AHB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= done;
      rdata_q  <= done ? rdata_d : '0;
      err_q    <= done & rspErr;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
`else
  assign rvalid_o = done;
  assign rdata_o  = rdata_d;
  assign err_o    = done & rspErr;
`endif

endmodule
